// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard/stall sequencer.
// The master side is the pipeline (it reports hazards). The slave side is the
// controller (it returns the pause/bubble controls).
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_redirect;
  logic             mdu_start;
  logic             mdu_done;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_pause;
  logic             if_id_pause;
  logic             if_id_bubble;
  logic             id_ex_pause;
  logic             id_ex_bubble;
  logic             ex_mem_pause;
  logic             ex_mem_bubble;
  logic             mem_wb_pause;
  logic             mem_wb_bubble;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_redirect, mdu_start, mdu_done, imem_ready, dmem_req, dmem_ready,
    input  pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
           ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble,
           mem_fault, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_redirect, mdu_start, mdu_done, imem_ready, dmem_req, dmem_ready,
    output pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
           ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble,
           mem_fault, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline.
// The sources are, from highest to lowest priority: dmem wait, MDU busy,
// branch redirect, load-use and fetch wait. Each source maps to pause/bubble
// controls on the four stage registers and to a PC hold. The block also drops
// wrong-path fetches after a redirect. It times out hung data accesses and
// counts stalled cycles.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic         clock,
  input logic         resetn,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT} state_t;

  localparam logic [7:0]       TIMEOUT_C = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic             kill_fetch_q, kill_fetch_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic timeout_now;
  logic p1_mem, p2_mdu, p3_redir, p4_lduse, p5_fetch;

  logic pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble;
  logic ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble, mem_fault;

  // Hazard detection terms shared by the next-state and output logic
  always_comb begin
    timeout_now = (state_q == MEM_WAIT) && (wait_cnt_q == TIMEOUT_C) && !bus.dmem_ready;
    p1_mem      = bus.dmem_req && !bus.dmem_ready && !timeout_now;
    p2_mdu      = !bus.mdu_done &&
                  ((state_q == MDU_WAIT) || ((state_q == RUN) && bus.mdu_start));
    p3_redir    = bus.ex_redirect;
    p4_lduse    = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                  ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    p5_fetch    = !bus.imem_ready || kill_fetch_q;
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: the dmem wait outranks the MDU wait, so an MDU wait stays put under a dmem stall
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (p1_mem) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (bus.mdu_start && !bus.mdu_done) begin
          state_d = MDU_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready || timeout_now) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      MDU_WAIT: begin
        if (!p1_mem && bus.mdu_done) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Output logic: the first matching hazard wins, and reset flushes every stage
  always_comb begin
    pc_pause      = 1'b0;
    if_id_pause   = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_pause   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_pause  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_pause  = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_fault     = 1'b0;
    if (!resetn) begin
      pc_pause      = 1'b1;
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      // A timed-out access is dropped: the MEM result never reaches writeback
      if (timeout_now) begin
        mem_fault     = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      if (p1_mem) begin
        pc_pause      = 1'b1;
        if_id_pause   = 1'b1;
        id_ex_pause   = 1'b1;
        ex_mem_pause  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (p2_mdu) begin
        pc_pause      = 1'b1;
        if_id_pause   = 1'b1;
        id_ex_pause   = 1'b1;
        ex_mem_bubble = 1'b1;
      end else if (p3_redir) begin
        if_id_bubble  = 1'b1;
        id_ex_bubble  = 1'b1;
      end else if (p4_lduse) begin
        pc_pause      = 1'b1;
        if_id_pause   = 1'b1;
        id_ex_bubble  = 1'b1;
      end else if (p5_fetch) begin
        pc_pause      = !bus.imem_ready;
        if_id_bubble  = 1'b1;
      end
    end
  end

  // Wrong-path fetch tracking: a redirect with a fetch still in flight marks the returning word for disposal
  always_comb begin
    kill_fetch_d = kill_fetch_q;
    if (p3_redir && !bus.imem_ready && !p1_mem && !p2_mdu) begin
      kill_fetch_d = 1'b1;
    end else if (bus.imem_ready) begin
      kill_fetch_d = 1'b0;
    end
  end

  // Saturating count of PC-hold cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_pause && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Auxiliary registers: kill flag and stall counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      kill_fetch_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      kill_fetch_q <= kill_fetch_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.pc_pause      = pc_pause;
  assign bus.if_id_pause   = if_id_pause;
  assign bus.if_id_bubble  = if_id_bubble;
  assign bus.id_ex_pause   = id_ex_pause;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.ex_mem_pause  = ex_mem_pause;
  assign bus.ex_mem_bubble = ex_mem_bubble;
  assign bus.mem_wb_pause  = mem_wb_pause;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.mem_fault     = mem_fault;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. The main instance uses MEM_TIMEOUT=4.
// A second instance has a 3-bit counter and a permanently stalled fetch, so
// the saturation of stall_cnt can be observed.
module tb_pipeline_ctrl;

  // Output vector order: pc, if_id_p, if_id_b, id_ex_p, id_ex_b, ex_mem_p, ex_mem_b, mem_wb_p, mem_wb_b, fault
  localparam logic [9:0] O_RST   = 10'b1010101010;
  localparam logic [9:0] O_IDLE  = 10'b0000000000;
  localparam logic [9:0] O_LU    = 10'b1100100000;
  localparam logic [9:0] O_MEM   = 10'b1101010010;
  localparam logic [9:0] O_MDU   = 10'b1101001000;
  localparam logic [9:0] O_REDIR = 10'b0010100000;
  localparam logic [9:0] O_FWP   = 10'b1010000000;
  localparam logic [9:0] O_FWK   = 10'b0010000000;
  localparam logic [9:0] O_FAULT = 10'b0000000011;

  logic clock;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  pipeline_ctrl_if #(.CNT_W(32)) bus ();
  pipeline_ctrl_if #(.CNT_W(3))  bus2 ();

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_sat (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [9:0] outs();
    return {bus.pc_pause, bus.if_id_pause, bus.if_id_bubble, bus.id_ex_pause,
            bus.id_ex_bubble, bus.ex_mem_pause, bus.ex_mem_bubble,
            bus.mem_wb_pause, bus.mem_wb_bubble, bus.mem_fault};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Check outputs and counter mid-cycle, then advance to just after the next rising edge
  task automatic step(input string tag, input logic [9:0] eo, input int ec);
    @(negedge clock);
    chk({tag, "_out"}, 32'(outs()), 32'(eo));
    chk({tag, "_cnt"}, bus.stall_cnt, 32'(ec));
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_is_load  = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.mdu_start   = 1'b0;
    bus.mdu_done    = 1'b0;
    bus.imem_ready  = 1'b1;
    bus.dmem_req    = 1'b0;
    bus.dmem_ready  = 1'b0;
  endtask

  initial begin
    clear_inputs();
    bus2.id_rs1      = 5'd0;
    bus2.id_rs2      = 5'd0;
    bus2.id_use_rs1  = 1'b0;
    bus2.id_use_rs2  = 1'b0;
    bus2.ex_rd       = 5'd0;
    bus2.ex_is_load  = 1'b0;
    bus2.ex_redirect = 1'b0;
    bus2.mdu_start   = 1'b0;
    bus2.mdu_done    = 1'b0;
    bus2.imem_ready  = 1'b0;
    bus2.dmem_req    = 1'b0;
    bus2.dmem_ready  = 1'b0;
    resetn = 1'b1;
    #2 resetn = 1'b0;

    // reset state
    step("rst", O_RST, 0);
    resetn = 1'b1;
    step("idle", O_IDLE, 0);
    chk("sat_a", 32'(bus2.stall_cnt), 32'd1);

    // load-use
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    step("lu_rs1", O_LU, 0);
    chk("sat_b", 32'(bus2.stall_cnt), 32'd2);
    bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    step("lu_x0", O_IDLE, 1);
    bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1; bus.id_use_rs1 = 1'b0; bus.id_rs1 = 5'd3;
    step("lu_rs2", O_LU, 1);
    bus.id_use_rs2 = 1'b0;
    step("lu_nouse", O_IDLE, 2);
    bus.id_use_rs2 = 1'b1; bus.ex_is_load = 1'b0;
    step("lu_noload", O_IDLE, 2);
    clear_inputs();

    // dmem stall for three cycles, released on ready
    bus.dmem_req = 1'b1;
    step("dm0", O_MEM, 2);
    step("dm1", O_MEM, 3);
    step("dm2", O_MEM, 4);
    bus.dmem_ready = 1'b1;
    step("dm_rel", O_IDLE, 5);
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    step("dm_idle", O_IDLE, 5);

    // dmem timeout after four waiting cycles
    bus.dmem_req = 1'b1;
    step("to0", O_MEM, 5);
    step("to1", O_MEM, 6);
    step("to2", O_MEM, 7);
    step("to3", O_MEM, 8);
    step("to_fault", O_FAULT, 9);
    bus.dmem_req = 1'b0;
    step("to_after", O_IDLE, 9);

    // MDU wait with a dmem stall in the middle
    bus.mdu_start = 1'b1;
    step("mdu0", O_MDU, 9);
    step("mdu1", O_MDU, 10);
    bus.dmem_req = 1'b1;
    step("mdu_mem", O_MEM, 11);
    bus.dmem_req = 1'b0;
    step("mdu3", O_MDU, 12);
    step("mdu4", O_MDU, 13);
    bus.mdu_done = 1'b1;
    step("mdu_done", O_IDLE, 14);
    bus.mdu_start = 1'b0; bus.mdu_done = 1'b0;
    step("mdu_run", O_IDLE, 14);
    chk("sat_hi", 32'(bus2.stall_cnt), 32'd7);

    // redirect with a fetch in flight
    bus.ex_redirect = 1'b1; bus.imem_ready = 1'b0;
    step("rd0", O_REDIR, 14);
    bus.ex_redirect = 1'b0;
    step("rd_wait", O_FWP, 14);
    bus.imem_ready = 1'b1;
    step("rd_kill", O_FWK, 15);
    step("rd_pass", O_IDLE, 15);

    // redirect is ignored under a dmem stall (no kill is armed)
    bus.ex_redirect = 1'b1; bus.imem_ready = 1'b0; bus.dmem_req = 1'b1;
    step("rdm0", O_MEM, 15);
    bus.ex_redirect = 1'b0; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    step("rdm1", O_IDLE, 16);
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    step("rdm2", O_IDLE, 16);

    // redirect with the fetch already back arms nothing
    bus.ex_redirect = 1'b1;
    step("rdr0", O_REDIR, 16);
    bus.ex_redirect = 1'b0;
    step("rdr1", O_IDLE, 16);

    // reset while in MDU wait
    bus.mdu_start = 1'b1;
    step("mr0", O_MDU, 16);
    step("mr1", O_MDU, 17);
    chk("sat_hold", 32'(bus2.stall_cnt), 32'd7);
    resetn = 1'b0;
    #1;
    chk("mr_rst_out", 32'(outs()), 32'(O_RST));
    chk("mr_rst_cnt", bus.stall_cnt, 32'd0);
    chk("mr_rst_sat", 32'(bus2.stall_cnt), 32'd0);
    @(posedge clock);
    #1;
    bus.mdu_start = 1'b0;
    resetn = 1'b1;
    step("post_rst0", O_IDLE, 0);
    step("post_rst1", O_IDLE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage pipeline.
- Drives the pause/bubble inputs of the four stage registers (if_id, id_ex, ex_mem, mem_wb) and the PC hold.
- Arbitrates five stall/flush sources by fixed priority: data-memory wait, multi-cycle MDU, branch redirect, load-use, instruction-fetch wait.
- Tracks in-flight wrong-path fetches, times out hung data accesses and counts stall cycles.

Parameters:
- MEM_TIMEOUT, 255: max consecutive dmem wait cycles before fault; legal 1..255.
- CNT_W, 32: width of the stall cycle counter.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch/jump (PC redirect this cycle)
- mdu_start  in  1  EX holds a multi-cycle mul/div op being issued
- mdu_done  in  1  MDU result valid this cycle
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  in  1  MEM stage has a load/store outstanding
- dmem_ready  in  1  data memory completes the access this cycle
- pc_pause  out  1  hold PC
- if_id_pause, if_id_bubble  out  1 each
- id_ex_pause, id_ex_bubble  out  1 each
- ex_mem_pause, ex_mem_bubble  out  1 each
- mem_wb_pause, mem_wb_bubble  out  1 each
- mem_fault  out  1  one-cycle pulse on dmem timeout
- stall_cnt  out  CNT_W  saturating count of cycles with pc_pause=1

Behaviour:
- FSM states: RUN, MEM_WAIT, MDU_WAIT.
- Additional registers: kill_fetch (1 b), wait_cnt (8 b), stall_cnt.
- Reset (resetn=0, asynchronous):
  - state=RUN, kill_fetch=0, wait_cnt=0, stall_cnt=0, mem_fault=0.
  - Outputs forced: pc_pause=1, all four *_bubble=1, all four *_pause=0, so stage registers flush to NOP/zero on every clock edge while in reset.
- Outputs are combinational from state, registers and inputs, evaluated in priority order; the first matching case wins. "Other" means the pause/bubble outputs not listed are 0.
  - P1 dmem stall: dmem_req & ~dmem_ready & ~timeout_now.
    - pc, if_id, id_ex, ex_mem pause=1; mem_wb_bubble=1.
  - P2 MDU stall: (state=MDU_WAIT & ~mdu_done) | (state=RUN & mdu_start & ~mdu_done).
    - pc, if_id, id_ex pause=1; ex_mem_bubble=1.
  - P3 redirect: ex_redirect.
    - if_id_bubble=1, id_ex_bubble=1; PC not paused.
  - P4 load-use: ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
    - pc, if_id pause=1; id_ex_bubble=1.
  - P5 fetch wait: ~imem_ready | kill_fetch.
    - pc_pause=~imem_ready; if_id_bubble=1.
  - Otherwise all outputs 0.
- Transitions:
  - RUN -> MEM_WAIT: on a P1 stall; wait_cnt=1.
  - MEM_WAIT:
    - dmem_ready -> RUN, wait_cnt=0.
    - Otherwise wait_cnt increments.
    - timeout_now = state=MEM_WAIT & wait_cnt==MEM_TIMEOUT & ~dmem_ready. When true: P1 is suppressed that cycle, mem_fault=1 for one cycle, the access is dropped (mem_wb bubbled), state -> RUN.
  - RUN -> MDU_WAIT: mdu_start & ~mdu_done & no P1 stall.
  - MDU_WAIT -> RUN: on mdu_done. That cycle ex_mem captures the result; P3–P5 are evaluated normally.
  - While in MDU_WAIT, a P1 stall (older instruction in MEM) takes priority; state stays MDU_WAIT.
- kill_fetch:
  - Set when ex_redirect & ~imem_ready & no P1/P2 stall (the in-flight fetch is wrong-path).
  - Cleared on the first cycle imem_ready=1; that returned instruction is bubbled into if_id.
  - Redirect while kill_fetch is already set: kill_fetch stays 1.
- ex_redirect during a P1/P2 stall is ignored (the EX stage is frozen); the upstream stage reasserts it on release.
- stall_cnt increments every non-reset cycle with pc_pause=1 and saturates at all-ones (no wrap).
- Reset mid-MEM_WAIT or mid-MDU_WAIT returns to RUN immediately; no mem_fault is generated.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1, imem_ready=1 -> pc_pause=1, if_id_pause=1, id_ex_bubble=1 for exactly 1 cycle. Repeat with ex_rd=0 -> no stall.
- dmem stall: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> pc/if_id/id_ex/ex_mem pause and mem_wb_bubble for 3 cycles, released on the ready cycle; stall_cnt +=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> stall for 4 cycles, then mem_fault=1 for 1 cycle, state RUN, no further pause.
- MDU: mdu_start=1, mdu_done after 5 cycles -> ex_mem_bubble=1 and upstream paused for 5 cycles; a concurrent dmem stall during the wait forces mem_wb_bubble and keeps state MDU_WAIT.
- Redirect with fetch pending: ex_redirect=1, imem_ready=0, then imem_ready=1 two cycles later -> if_id_bubble on the redirect cycle and again on the returning fetch; kill_fetch clears; the next fetch passes.
- Reset: assert resetn=0 mid-MDU_WAIT -> immediately pc_pause=1, all bubbles=1, stall_cnt=0; after release, state RUN and all outputs 0 with imem_ready=1.
